// File: rtl/dfd_cla_pkg.sv
// Shared types and constants for the multi-channel CLA action generator.
// The channel state struct is sized by the CH_* widths below.
package dfd_cla_pkg;

    localparam int XTRIG_BASE   = 8;
    localparam int HALT_IDX     = 2;
    localparam int CH_DELAY_W   = 7;
    localparam int CH_STRETCH_W = 4;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_WAIT = 1'b1
    } ch_state_e;

    typedef struct packed {
        ch_state_e                state;
        logic [CH_DELAY_W-1:0]    cnt;
        logic [CH_STRETCH_W-1:0]  stretch_cnt;
    } chan_state_t;

    localparam chan_state_t CHAN_RESET = '{state: CH_IDLE, cnt: '0, stretch_cnt: '0};

    // Loop-delay counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CH_DELAY_W-1:0] sat_inc(input logic [CH_DELAY_W-1:0] v);
        logic [CH_DELAY_W-1:0] r;
        if (v == {CH_DELAY_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CH_DELAY_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/dfd_cla_xtrig_chan.sv
// One cross-trigger channel: output pulse stretcher plus self-filter timer.
// Build option DFD_CLA_ACTGEN_RETRIG_EN lets a trigger during WAIT restart the timer.
module dfd_cla_xtrig_chan
    import dfd_cla_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    trig_i,
    input  logic [CH_DELAY_W-1:0]   delay_i,
    input  logic [CH_STRETCH_W-1:0] stretch_i,
    output logic                    xtrigger_o,
    output logic                    self_filter_o
);

    chan_state_t           chan_q;
    chan_state_t           chan_d;
    logic [CH_DELAY_W-1:0] cnt_inc_s;
    logic                  self_filter_s;

    // Next-state for stretch counter and self-filter FSM.
    always_comb begin
        chan_d        = chan_q;
        self_filter_s = 1'b0;
        cnt_inc_s     = sat_inc(chan_q.cnt);

        if (trig_i) begin
            chan_d.stretch_cnt = stretch_i;
        end else if (chan_q.stretch_cnt != '0) begin
            chan_d.stretch_cnt = chan_q.stretch_cnt - CH_STRETCH_W'(1);
        end else begin
            chan_d.stretch_cnt = chan_q.stretch_cnt;
        end

        case (chan_q.state)
            CH_IDLE: begin
                if (trig_i && (delay_i == '0)) begin
                    self_filter_s = 1'b1;
                end else if (trig_i) begin
                    chan_d.cnt   = CH_DELAY_W'(1);
                    chan_d.state = CH_WAIT;
                end else begin
                    chan_d.state = CH_IDLE;
                end
            end
            CH_WAIT: begin
                // Compare against the incremented count so the pulse lands delay-1 cycles after entry.
`ifdef DFD_CLA_ACTGEN_RETRIG_EN
                if (trig_i) begin
                    chan_d.cnt = CH_DELAY_W'(1);
                end else if (cnt_inc_s >= delay_i) begin
                    self_filter_s = 1'b1;
                    chan_d.cnt    = '0;
                    chan_d.state  = CH_IDLE;
                end else begin
                    chan_d.cnt = cnt_inc_s;
                end
`else
                if (cnt_inc_s >= delay_i) begin
                    self_filter_s = 1'b1;
                    chan_d.cnt    = '0;
                    chan_d.state  = CH_IDLE;
                end else begin
                    chan_d.cnt = cnt_inc_s;
                end
`endif
            end
            default: begin
                chan_d = CHAN_RESET;
            end
        endcase
    end

    // Channel state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chan_q <= CHAN_RESET;
        end else begin
            chan_q <= chan_d;
        end
    end

    assign xtrigger_o    = trig_i | (chan_q.stretch_cnt != '0);
    assign self_filter_o = self_filter_s;

endmodule

// File: rtl/dfd_cla_action_gen_mc.sv
// Multi-channel CLA action generator: EAP node tracking, action registers, xtrigger channels, clock halt.
// Build option DFD_CLA_ACTGEN_RETRIG_EN enables self-filter restart on retrigger in every channel.
module dfd_cla_action_gen_mc #(
    parameter int  NUM_NODES   = 4,
    parameter int  NUM_ACTIONS = 32,
    parameter int  NUM_CUSTOM  = 8,
    parameter int  NUM_XTRIG   = 4,
    parameter int  XTRIG_BASE  = dfd_cla_pkg::XTRIG_BASE,
    parameter int  HALT_IDX    = dfd_cla_pkg::HALT_IDX,
    parameter int  DELAY_W     = dfd_cla_pkg::CH_DELAY_W,
    parameter int  STRETCH_W   = dfd_cla_pkg::CH_STRETCH_W,
    localparam int NODE_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  reset_n_warm_ovrride,
    input  logic                                  enable_eap,
    input  logic [NUM_NODES-1:0][NUM_ACTIONS-1:0] node_action_bus,
    input  logic [NUM_NODES-1:0][NUM_CUSTOM-1:0]  node_custom_action_bus,
    input  logic [NUM_NODES-1:0][NODE_W-1:0]      next_destination_node_id,
    input  logic [NUM_XTRIG-1:0][DELAY_W-1:0]     chain_loop_delay,
    input  logic [NUM_XTRIG-1:0][STRETCH_W-1:0]   xtrig_stretch,
    input  logic                                  clock_halt_en,
    input  logic                                  clock_halt_clear,
    output logic [NUM_ACTIONS-1:0]                action_bus,
    output logic [NUM_CUSTOM-1:0]                 custom_action_bus,
    output logic [NUM_XTRIG-1:0]                  xtrigger_out,
    output logic [NUM_XTRIG-1:0]                  self_filter,
    output logic                                  clock_halt,
    output logic [NODE_W-1:0]                     current_node_id
);

    import dfd_cla_pkg::*;

    localparam logic [NODE_W:0] NODE_LIMIT = (NODE_W+1)'(NUM_NODES);

    logic [NODE_W-1:0]      node_q;
    logic [NODE_W-1:0]      node_d;
    logic [NODE_W-1:0]      dest_s;
    logic                   cur_ok_s;
    logic                   dest_ok_s;
    logic [NUM_ACTIONS-1:0] action_q;
    logic [NUM_ACTIONS-1:0] action_d;
    logic [NUM_CUSTOM-1:0]  custom_q;
    logic [NUM_CUSTOM-1:0]  custom_d;
    logic                   halt_q;
    logic                   halt_d;
    logic [NUM_XTRIG-1:0]   trig_s;

    if ((DELAY_W != CH_DELAY_W) || (STRETCH_W != CH_STRETCH_W)) begin : g_width_chk
        $error("channel widths must match dfd_cla_pkg CH_DELAY_W/CH_STRETCH_W");
    end

    // Node successor and action selection; any out-of-range ID maps to node 0 / zero actions.
    always_comb begin
        cur_ok_s = ({1'b0, node_q} < NODE_LIMIT);
        if (cur_ok_s) begin
            dest_s   = next_destination_node_id[node_q];
            action_d = node_action_bus[node_q];
            custom_d = node_custom_action_bus[node_q];
        end else begin
            dest_s   = '0;
            action_d = '0;
            custom_d = '0;
        end
        dest_ok_s = ({1'b0, dest_s} < NODE_LIMIT);
        if (enable_eap && dest_ok_s) begin
            node_d = dest_s;
        end else begin
            node_d = '0;
        end
    end

    // Sticky halt: a set in the same cycle as a clear wins.
    always_comb begin
        if (action_q[HALT_IDX] && clock_halt_en) begin
            halt_d = 1'b1;
        end else if (clock_halt_clear) begin
            halt_d = 1'b0;
        end else begin
            halt_d = halt_q;
        end
    end

    // Current node register, reset only by the warm-override reset.
    always_ff @(posedge clock or negedge reset_n_warm_ovrride) begin
        if (!reset_n_warm_ovrride) begin
            node_q <= '0;
        end else begin
            node_q <= node_d;
        end
    end

    // Action, custom-action and halt registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            action_q <= '0;
            custom_q <= '0;
            halt_q   <= 1'b0;
        end else begin
            action_q <= action_d;
            custom_q <= custom_d;
            halt_q   <= halt_d;
        end
    end

    assign trig_s = action_q[XTRIG_BASE +: NUM_XTRIG];

    for (genvar i = 0; i < NUM_XTRIG; i++) begin : g_chan
        dfd_cla_xtrig_chan u_chan (
            .clock         (clock),
            .reset_n       (reset_n),
            .trig_i        (trig_s[i]),
            .delay_i       (chain_loop_delay[i]),
            .stretch_i     (xtrig_stretch[i]),
            .xtrigger_o    (xtrigger_out[i]),
            .self_filter_o (self_filter[i])
        );
    end

    assign action_bus        = action_q;
    assign custom_action_bus = custom_q;
    assign clock_halt        = halt_q;
    assign current_node_id   = node_q;

endmodule

// File: tb/tb_dfd_cla_action_gen_mc.sv
// Directed bench for dfd_cla_action_gen_mc: per-cycle vector table for the channels and halt,
// plus hand sequences for the node walk and the two resets.
module tb_dfd_cla_action_gen_mc;

`ifdef DFD_CLA_ACTGEN_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam logic [31:0] T0 = 32'h0000_0100;
    localparam logic [31:0] T1 = 32'h0000_0200;
    localparam logic [31:0] T2 = 32'h0000_0400;
    localparam logic [31:0] T3 = 32'h0000_0800;
    localparam logic [31:0] HB = 32'h0000_0004;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              warm_n;
    logic              enable_eap;
    logic [3:0][31:0]  nab;
    logic [3:0][7:0]   ncab;
    logic [3:0][1:0]   dest;
    logic [3:0][6:0]   cld;
    logic [3:0][3:0]   xs;
    logic              halt_en;
    logic              halt_clr;
    logic [31:0]       action_bus;
    logic [7:0]        custom_action_bus;
    logic [3:0]        xtrigger_out;
    logic [3:0]        self_filter;
    logic              clock_halt;
    logic [1:0]        current_node_id;

    dfd_cla_action_gen_mc dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .reset_n_warm_ovrride     (warm_n),
        .enable_eap               (enable_eap),
        .node_action_bus          (nab),
        .node_custom_action_bus   (ncab),
        .next_destination_node_id (dest),
        .chain_loop_delay         (cld),
        .xtrig_stretch            (xs),
        .clock_halt_en            (halt_en),
        .clock_halt_clear         (halt_clr),
        .action_bus               (action_bus),
        .custom_action_bus        (custom_action_bus),
        .xtrigger_out             (xtrigger_out),
        .self_filter              (self_filter),
        .clock_halt               (clock_halt),
        .current_node_id          (current_node_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] act;
        logic        en;
        logic        clr;
        logic [3:0]  xt;
        logic [3:0]  sf;
        logic        halt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic addv(input logic [31:0] act, input logic en, input logic clr,
                        input logic [3:0] xt, input logic [3:0] sf, input logic h);
        vec_t v;
        v.act  = act;
        v.en   = en;
        v.clr  = clr;
        v.xt   = xt;
        v.sf   = sf;
        v.halt = h;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] ea;
        logic [7:0]  ec;

        reset_n    = 1'b0;
        warm_n     = 1'b0;
        enable_eap = 1'b0;
        nab        = '0;
        ncab       = '0;
        dest[0]    = 2'd1;
        dest[1]    = 2'd2;
        dest[2]    = 2'd3;
        dest[3]    = 2'd0;
        cld[0]     = 7'd0;
        cld[1]     = 7'd5;
        cld[2]     = 7'd0;
        cld[3]     = 7'd5;
        xs[0]      = 4'd0;
        xs[1]      = 4'd0;
        xs[2]      = 4'd3;
        xs[3]      = 4'd0;
        halt_en    = 1'b0;
        halt_clr   = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst action", action_bus, 32'h0);
        chk("rst custom", 32'(custom_action_bus), 32'h0);
        chk("rst xtrig", 32'(xtrigger_out), 32'h0);
        chk("rst sfilt", 32'(self_filter), 32'h0);
        chk("rst halt", 32'(clock_halt), 32'h0);
        chk("rst node", 32'(current_node_id), 32'h0);
        reset_n = 1'b1;
        warm_n  = 1'b1;

        // rows: action on node 0, halt_en, halt_clear, exp xtrigger, exp self_filter, exp halt
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(T0,    1'b0, 1'b0, 4'h1, 4'h1, 1'b0);   // delay 0: filter with trigger
        repeat (2) addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(T1,    1'b0, 1'b0, 4'h2, 4'h0, 1'b0);   // delay 5 at T=4
        repeat (3) addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0);   // T+4
        repeat (2) addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(T3,    1'b0, 1'b0, 4'h8, 4'h0, 1'b0);   // retrigger at T=11 and T+2
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(T3,    1'b0, 1'b0, 4'h8, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, RETRIG ? 4'h0 : 4'h8, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, RETRIG ? 4'h8 : 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(T2,    1'b0, 1'b0, 4'h4, 4'h4, 1'b0);   // stretch 3, isolated
        repeat (3) addv(32'h0, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(T2,    1'b0, 1'b0, 4'h4, 4'h4, 1'b0);   // stretch 3, retrigger at T+2
        addv(32'h0, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0);
        addv(T2,    1'b0, 1'b0, 4'h4, 4'h4, 1'b0);
        repeat (3) addv(32'h0, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(HB,    1'b1, 1'b0, 4'h0, 4'h0, 1'b0);   // halt action with clear: set wins
        addv(32'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
        addv(32'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(HB,    1'b0, 1'b0, 4'h0, 4'h0, 1'b0);   // unarmed halt action
        addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        addv(HB,    1'b1, 1'b0, 4'h0, 4'h0, 1'b0);   // armed, then sticky
        addv(32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        repeat (2) addv(32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

        for (int k = 0; k < vq.size(); k++) begin
            nab[0]   = vq[k].act;
            halt_en  = vq[k].en;
            halt_clr = vq[k].clr;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("v%0d action", k), action_bus, vq[k].act);
            chk($sformatf("v%0d xtrig", k), 32'(xtrigger_out), 32'(vq[k].xt));
            chk($sformatf("v%0d sfilt", k), 32'(self_filter), 32'(vq[k].sf));
            chk($sformatf("v%0d halt", k), 32'(clock_halt), 32'(vq[k].halt));
        end

        // Node walk 0,1,2,3,0 with actions trailing by one cycle.
        for (int k = 0; k < 4; k++) begin
            nab[k]  = 32'h1 << k;
            ncab[k] = 8'hA0 | 8'(k);
        end
        halt_en    = 1'b0;
        halt_clr   = 1'b0;
        enable_eap = 1'b1;
        chk("walk node0", 32'(current_node_id), 32'h0);
        for (int j = 1; j <= 5; j++) begin
            @(posedge clock);
            @(negedge clock);
            ea = 32'h1 << ((j - 1) % 4);
            ec = 8'hA0 | 8'((j - 1) % 4);
            chk($sformatf("walk%0d node", j), 32'(current_node_id), 32'(j % 4));
            chk($sformatf("walk%0d action", j), action_bus, ea);
            chk($sformatf("walk%0d custom", j), 32'(custom_action_bus), 32'(ec));
            chk($sformatf("walk%0d halt", j), 32'(clock_halt), 32'h1);
        end

        // Warm reset alone: node clears, everything else holds.
        #2 warm_n = 1'b0;
        #1;
        chk("warm node", 32'(current_node_id), 32'h0);
        chk("warm halt", 32'(clock_halt), 32'h1);
        chk("warm action", action_bus, 32'h1);
        @(negedge clock);
        chk("warm held node", 32'(current_node_id), 32'h0);
        warm_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("post warm node", 32'(current_node_id), 32'h1);

        // Cold reset leaves the node alone; enable low then forces node 0.
        enable_eap = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("cold halt", 32'(clock_halt), 32'h0);
        chk("cold action", action_bus, 32'h0);
        chk("cold node", 32'(current_node_id), 32'h1);
        @(negedge clock);
        chk("noeap node", 32'(current_node_id), 32'h0);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
